// File: rtl/park_gate_ctrl.sv
// Car-park entry gate controller: keypad passcode entry with timeout, brute-force
// lockout, occupancy tracking with full-lot blocking, and tailgate detection.
module park_gate_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 64,
  parameter int CAPACITY    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sensor_front,
  input  logic                             sensor_back,
  input  logic                             car_exit,
  input  logic                             in_enable,
  input  logic [DIGIT_W-1:0]               pass_digit,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]    password,
  output logic                             open_gate,
  output logic                             green,
  output logic                             red,
  output logic [2:0]                       state,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
  output logic                             full
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int OCC_W = $clog2(CAPACITY + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [LCK_W-1:0] LCK_LAST  = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [OCC_W-1:0] OCC_CAP   = OCC_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    WRONG_PASS = 3'd2,
    RIGHT_PASS = 3'd3,
    STOP       = 3'd4,
    LOCKED     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TRY_W-1:0]     tries_q, tries_d, tries_inc;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [LCK_W-1:0]     lock_q, lock_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 green_q, green_d;
  logic                 red_q, red_d;
  logic                 open_q, open_d;
  logic [DIGIT_W-1:0]   digits_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]   digits_d [NUM_DIGITS];
  logic                 code_match;
  logic                 red_pulse;
  logic                 car_in;

  // The final digit is compared straight off the keypad so the verdict lands on the capture edge.
  always_comb begin
    code_match = (pass_digit == password[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W]);
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (digits_q[k] != password[k*DIGIT_W +: DIGIT_W]) code_match = 1'b0;
    end
  end

  assign tries_inc = tries_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    tmo_d     = tmo_q;
    lock_d    = '0;
    digits_d  = digits_q;
    red_pulse = 1'b0;
    car_in    = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        tmo_d = '0;
        if (sensor_front) begin
          if (full_q) red_pulse = 1'b1;
          else        state_d   = WAIT_PASS;
        end
      end

      WAIT_PASS, WRONG_PASS, STOP: begin
        if (in_enable) begin
          digits_d[idx_q] = pass_digit;
          tmo_d           = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (code_match) begin
              tries_d = '0;
              if (full_q) begin
                state_d   = IDLE;
                red_pulse = 1'b1;
              end else begin
                state_d = RIGHT_PASS;
              end
            end else begin
              tries_d = tries_inc;
              state_d = (tries_inc == TRY_MAX) ? LOCKED : WRONG_PASS;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          tries_d = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RIGHT_PASS: begin
        tries_d = '0;
        idx_d   = '0;
        tmo_d   = '0;
        if (sensor_back) begin
          car_in  = 1'b1;
          state_d = sensor_front ? STOP : IDLE;
        end
      end

      LOCKED: begin
        idx_d = '0;
        tmo_d = '0;
        if (lock_q == LCK_LAST) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (car_in && !car_exit && occ_q != OCC_CAP)      occ_d = occ_q + 1'b1;
    else if (car_exit && !car_in && occ_q != '0)      occ_d = occ_q - 1'b1;
    full_d  = (occ_d == OCC_CAP);
    green_d = (state_d == RIGHT_PASS);
    open_d  = (state_d == RIGHT_PASS);
    red_d   = red_pulse || (state_d == WRONG_PASS) || (state_d == STOP) || (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tries_q  <= '0;
      tmo_q    <= '0;
      lock_q   <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      green_q  <= 1'b0;
      red_q    <= 1'b0;
      open_q   <= 1'b0;
      digits_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      tmo_q    <= tmo_d;
      lock_q   <= lock_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      green_q  <= green_d;
      red_q    <= red_d;
      open_q   <= open_d;
      digits_q <= digits_d;
    end
  end

  assign state     = state_q;
  assign open_gate = open_q;
  assign green     = green_q;
  assign red       = red_q;
  assign occupancy = occ_q;
  assign full      = full_q;

endmodule
